// File: rtl/risc_multicycle_core.sv
// Multi-cycle RISC core: FETCH/EXEC/MEM/HALT sequencer with a register file, an ALU and a Z flag.
// Instruction and data memories are external and use req/ready handshakes, so they may insert wait states.
module risc_multicycle_core #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [ADDR_W+3:0] imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              zero_flag,
   output logic              retire,
   output logic              halted
);
   localparam int RSEL_W = $clog2(NUM_REGS);
   localparam int IR_W   = ADDR_W + 4;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_NOT  = 4'h4;
   localparam logic [3:0] OP_RDA  = 4'h5;
   localparam logic [3:0] OP_RDB  = 4'h6;
   localparam logic [3:0] OP_WRA  = 4'h7;
   localparam logic [3:0] OP_WRB  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_BZ   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [IR_W-1:0]     ir_q;
   logic                z_q;

   logic [3:0]          op;
   logic [ADDR_W-1:0]   addr_f;
   logic [RSEL_W-1:0]   ra;
   logic [RSEL_W-1:0]   rb;
   logic [ADDR_W-1:0]   pc_inc;
   logic [DATA_W-1:0]   reg_rd [NUM_REGS];
   logic [DATA_W-1:0]   ra_val;
   logic [DATA_W-1:0]   rb_val;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_op;
   logic                is_mem;
   logic                is_wr;
   logic [NUM_REGS-1:0] reg_we;
   logic [DATA_W-1:0]   reg_wdata;

   assign op     = ir_q[IR_W-1:ADDR_W];
   assign addr_f = ir_q[ADDR_W-1:0];
   assign rb     = ir_q[RSEL_W-1:0];
   assign ra     = ir_q[2*RSEL_W-1:RSEL_W];
   assign pc_inc = pc_q + 1'b1;
   assign ra_val = reg_rd[ra];
   assign rb_val = reg_rd[rb];
   assign is_mem = (op == OP_RDA) || (op == OP_RDB) || (op == OP_WRA) || (op == OP_WRB);
   assign is_wr  = (op == OP_WRA) || (op == OP_WRB);

   always_comb begin
      alu_res = '0;
      alu_op  = 1'b0;
      case (op)
         OP_ADD:  begin alu_res = ra_val + rb_val; alu_op = 1'b1; end
         OP_SUB:  begin alu_res = ra_val - rb_val; alu_op = 1'b1; end
         OP_AND:  begin alu_res = ra_val & rb_val; alu_op = 1'b1; end
         OP_NOT:  begin alu_res = ~ra_val;         alu_op = 1'b1; end
         default: ;
      endcase
   end

   // ALU results land in rb during EXEC; memory reads land in r0/r1 when the data access completes.
   always_comb begin
      reg_we    = '0;
      reg_wdata = alu_op ? alu_res : dmem_rdata;
      if (state_q == S_EXEC && alu_op)
         reg_we[rb] = 1'b1;
      if (state_q == S_MEM && dmem_ready && op == OP_RDA)
         reg_we[0] = 1'b1;
      if (state_q == S_MEM && dmem_ready && op == OP_RDB)
         reg_we[1] = 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] r_q;
         always_ff @(posedge clk) begin
            if (reset)
               r_q <= '0;
            else if (reg_we[gi])
               r_q <= reg_wdata;
         end
         assign reg_rd[gi] = r_q;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  ir_q    <= imem_rdata;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (alu_op)
                  z_q <= (alu_res == '0);
               if (is_mem) begin
                  state_q <= S_MEM;
               end else if (op == OP_HALT) begin
                  pc_q    <= pc_inc;
                  state_q <= S_HALT;
               end else begin
                  state_q <= S_FETCH;
                  if (op == OP_JMP)
                     pc_q <= addr_f;
                  else if (op == OP_BZ)
                     pc_q <= z_q ? addr_f : pc_inc;
                  else
                     pc_q <= pc_inc;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  pc_q    <= pc_inc;
                  state_q <= S_FETCH;
               end
            end
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   // Every output is forced low while reset is held, so an abandoned access drops its request immediately.
   assign imem_req   = !reset && (state_q == S_FETCH);
   assign imem_addr  = reset ? '0 : pc_q;
   assign pc         = reset ? '0 : pc_q;
   assign dmem_req   = !reset && (state_q == S_MEM);
   assign dmem_we    = dmem_req && is_wr;
   assign dmem_addr  = dmem_req ? addr_f : '0;
   assign dmem_wdata = dmem_we ? ((op == OP_WRA) ? reg_rd[0] : reg_rd[1]) : '0;
   assign zero_flag  = !reset && z_q;
   assign halted     = !reset && (state_q == S_HALT);
   assign retire     = !reset && (((state_q == S_EXEC) && !is_mem) ||
                                  ((state_q == S_MEM) && dmem_ready));
endmodule

// File: tb/tb_risc_multicycle_core.sv
// Directed bench for risc_multicycle_core: bench-side memories, expected retire PCs and memory writes
// are queued as each program is loaded and popped as the core retires instructions and commits writes.
module tb_risc_multicycle_core;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       imem_req;
   logic [3:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_ready;
   logic       dmem_req;
   logic       dmem_we;
   logic [3:0] dmem_addr;
   logic [7:0] dmem_wdata;
   logic [7:0] dmem_rdata;
   logic       dmem_ready = 1'b0;
   logic [3:0] pc;
   logic       zero_flag;
   logic       retire;
   logic       halted;

   logic [7:0]  imem [16];
   logic [7:0]  dmem [16];
   logic [3:0]  exp_pc_q [$];
   logic [11:0] exp_wr_q [$];

   int vectors = 0;
   int miscompares = 0;
   int dwait = 0;
   int wcnt = 0;
   int retire_cnt = 0;
   int rd_hold = 0;
   int snap_hold;
   int snap_ret;

   always #5 clk = ~clk;

   assign imem_ready = imem_req;
   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   risc_multicycle_core #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(4)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .pc(pc), .zero_flag(zero_flag), .retire(retire), .halted(halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: data memory wait-state model, then scoreboard pops on retire and on committed writes.
   task automatic tick();
      logic [3:0]  epc;
      logic [11:0] ewr;
      @(negedge clk);
      if (dmem_req) wcnt++; else wcnt = 0;
      dmem_ready = dmem_req && (wcnt > dwait);
      #1;
      if (dmem_req && !dmem_we && dmem_addr == 4'hA) rd_hold++;
      if (retire) begin
         retire_cnt++;
         check("retire_expected", 32'(exp_pc_q.size() > 0), 32'd1);
         if (exp_pc_q.size() > 0) begin
            epc = exp_pc_q.pop_front();
            check("retire_pc", 32'(pc), 32'(epc));
            $display("retire pc=%0h", pc);
         end
      end
      if (dmem_req && dmem_we && dmem_ready) begin
         check("write_expected", 32'(exp_wr_q.size() > 0), 32'd1);
         if (exp_wr_q.size() > 0) begin
            ewr = exp_wr_q.pop_front();
            check("mem_write", 32'({dmem_addr, dmem_wdata}), 32'(ewr));
            $display("write mem[%0h]=%0h", dmem_addr, dmem_wdata);
         end
         dmem[dmem_addr] = dmem_wdata;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag, 32'({imem_req, dmem_req, dmem_we, retire, halted, zero_flag,
                      pc, imem_addr, dmem_addr, dmem_wdata}), 32'd0);
   endtask

   task automatic begin_test();
      reset = 1'b1;
      dwait = 0;
      wcnt = 0;
      dmem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         imem[i] = 8'hF0;
         dmem[i] = 8'h00;
      end
      exp_pc_q.delete();
      exp_wr_q.delete();
   endtask

   task automatic release_reset(input int n);
      #1;
      check_reset_outputs("reset_outputs");
      repeat (n) tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic run_to_halt(input string tag, input int max);
      int n = 0;
      while (!halted && n < max) begin
         tick();
         n++;
      end
      check({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   task automatic end_test(input string tag);
      check({tag, "_pc_queue_drained"}, 32'(exp_pc_q.size()), 32'd0);
      check({tag, "_wr_queue_drained"}, 32'(exp_wr_q.size()), 32'd0);
   endtask

   initial begin
      // 1: reset state; registers and Z observed through stores and a not-taken BZ
      begin_test();
      imem[0] = 8'h70; imem[1] = 8'h81; imem[2] = 8'hA5; imem[3] = 8'hF0;
      dmem[0] = 8'h11; dmem[1] = 8'h22;
      exp_pc_q = '{4'h0, 4'h1, 4'h2, 4'h3};
      exp_wr_q = '{{4'h0, 8'h00}, {4'h1, 8'h00}};
      release_reset(2);
      check("t1_after_reset", 32'({imem_req, imem_addr, halted, zero_flag, pc}),
            32'({1'b1, 4'h0, 1'b0, 1'b0, 4'h0}));
      run_to_halt("t1", 100);
      end_test("t1");

      // 2: load, load, add, store, halt
      begin_test();
      imem[0] = 8'h53; imem[1] = 8'h64; imem[2] = 8'h11; imem[3] = 8'h85; imem[4] = 8'hF0;
      dmem[3] = 8'h05; dmem[4] = 8'h03;
      exp_pc_q = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
      exp_wr_q = '{{4'h5, 8'h08}};
      snap_ret = retire_cnt;
      release_reset(2);
      run_to_halt("t2", 100);
      check("t2_retire_count", 32'(retire_cnt - snap_ret), 32'd5);
      check("t2_no_fetch_when_halted", 32'({imem_req, dmem_req}), 32'd0);
      end_test("t2");

      // 3: SUB ra==rb then taken BZ; SUB ra!=rb then not-taken BZ
      begin_test();
      imem[0] = 8'h53; imem[1] = 8'h25; imem[2] = 8'hA9;
      imem[9] = 8'h21; imem[10] = 8'hAC; imem[11] = 8'h85; imem[12] = 8'hF0;
      dmem[3] = 8'h05;
      exp_pc_q = '{4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC};
      exp_wr_q = '{{4'h5, 8'h05}};
      release_reset(2);
      run_to_halt("t3", 100);
      check("t3_zero_flag", 32'(zero_flag), 32'd0);
      end_test("t3");

      // 4: three data wait states on RD_A and WR_A
      begin_test();
      imem[0] = 8'h5A; imem[1] = 8'h7B; imem[2] = 8'hF0;
      dmem[10] = 8'h3C;
      dwait = 3;
      exp_pc_q = '{4'h0, 4'h1, 4'h2};
      exp_wr_q = '{{4'hB, 8'h3C}};
      snap_hold = rd_hold;
      snap_ret = retire_cnt;
      release_reset(2);
      run_to_halt("t4", 100);
      check("t4_rd_req_hold_cycles", 32'(rd_hold - snap_hold), 32'd4);
      check("t4_retire_count", 32'(retire_cnt - snap_ret), 32'd3);
      end_test("t4");

      // 5: 0xFF+0x01 wraps to zero with Z set; NOP at 0xF wraps the pc to 0
      begin_test();
      imem[0] = 8'hA9; imem[1] = 8'h56; imem[2] = 8'h67; imem[3] = 8'h11;
      imem[4] = 8'h88; imem[5] = 8'hAF; imem[15] = 8'h00; imem[9] = 8'hF0;
      dmem[6] = 8'hFF; dmem[7] = 8'h01; dmem[8] = 8'h55;
      exp_pc_q = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 4'h0, 4'h9};
      exp_wr_q = '{{4'h8, 8'h00}};
      release_reset(2);
      run_to_halt("t5", 100);
      check("t5_zero_flag", 32'(zero_flag), 32'd1);
      end_test("t5");

      // 6a: reset while WR_A waits on dmem_ready abandons the write
      begin_test();
      imem[0] = 8'h7D;
      dmem[13] = 8'hAA;
      dwait = 3;
      release_reset(2);
      for (int n = 0; n < 10 && !dmem_req; n++) tick();
      check("t6_mem_entered", 32'(dmem_req), 32'd1);
      tick();
      reset = 1'b1;
      #1;
      check_reset_outputs("t6_mid_mem_reset_outputs");
      imem[0] = 8'hF0;
      exp_pc_q.push_back(4'h0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_fetch_resumes", 32'({imem_req, imem_addr, pc}), 32'({1'b1, 4'h0, 4'h0}));
      run_to_halt("t6a", 50);
      check("t6_mem_untouched", 32'(dmem[13]), 32'h0000_00AA);
      end_test("t6a");

      // 6b: reset during HALT
      reset = 1'b1;
      #1;
      check_reset_outputs("t6_halt_reset_outputs");
      exp_pc_q.push_back(4'h0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_halt_fetch_resumes", 32'({imem_req, imem_addr, halted}), 32'({1'b1, 4'h0, 1'b0}));
      run_to_halt("t6b", 50);
      end_test("t6b");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
